// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with one-cycle memory, prefetch FIFO and redirect flush.
// Define IF_FETCH_PERF_EN to add the perf_fetched/perf_flushed counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_ins,
    output logic [31:0] dec_ins,
    output logic [31:0] dec_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, inflight_pc_q, last_ins_q, last_pc_q;
    logic          inflight_q, issue, push, pop;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, occ;
    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];

    // credit check counts the in-flight word so a push can never overflow
    assign occ       = count + CW'(inflight_q);
    assign issue     = !redirect && (occ < CW'(DEPTH));
    assign push      = inflight_q && !redirect;
    assign dec_valid = count != '0;
    assign pop       = dec_valid && dec_ready && !redirect;
    assign imem_pc   = pc_q;
    assign dec_ins   = dec_valid ? ins_mem[rd_ptr] : last_ins_q;
    assign dec_pc    = dec_valid ? pc_mem[rd_ptr] : last_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            last_ins_q    <= 32'h0;
            last_pc_q     <= 32'h0;
        end else if (redirect) begin
            pc_q       <= redirect_pc & ~32'h3;
            inflight_q <= 1'b0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                last_ins_q <= ins_mem[rd_ptr];
                last_pc_q  <= pc_mem[rd_ptr];
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr] <= imem_ins;
            pc_mem[wr_ptr]  <= inflight_pc_q;
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'h0;
            perf_flushed <= 32'h0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (redirect) perf_flushed <= perf_flushed + 32'(occ);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch, back-pressure, redirect, wrap and reset.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pc, imem_ins = 32'h0, dec_ins, dec_pc;
    logic        dec_valid, dec_ready = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int          checks = 0;
    int          failures = 0;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    if_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_ins(imem_ins),
        .dec_ins(dec_ins), .dec_pc(dec_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) imem_ins <= mem_word(imem_pc);

    // a push into a full FIFO would be a credit-logic bug
    always @(posedge clk) begin
        if (rst_n && !redirect && dut.inflight_q && dut.count >= 4) begin
            failures++;
            $display("FAIL overflow count=%0d required<4", dut.count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n = 1'b0;
        redirect = 1'b0;
        dec_ready = ready;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_pc !== 32'h0) begin failures++; $display("FAIL rst_imem_pc got=%h exp=%h", imem_pc, 32'h0); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", dec_valid); end
        checks++; if (dec_ins !== 32'h0) begin failures++; $display("FAIL rst_ins got=%h exp=0", dec_ins); end
        checks++; if (dec_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", dec_pc); end
`ifdef IF_FETCH_PERF_EN
        checks++; if (perf_fetched !== 32'h0 || perf_flushed !== 32'h0) begin failures++; $display("FAIL rst_perf got=%h/%h exp=0/0", perf_fetched, perf_flushed); end
`endif
    endtask

    task automatic test_basic();
        do_reset(1'b1);
        tick();
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL basic_e1_valid got=%b exp=0", dec_valid); end
        checks++; if (imem_pc !== 32'h4) begin failures++; $display("FAIL basic_e1_pc got=%h exp=4", imem_pc); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_ins !== 32'h0000_0013) begin failures++; $display("FAIL basic_e2 got=%b/%h/%h exp=1/0/00000013", dec_valid, dec_pc, dec_ins); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4 || dec_ins !== 32'h0010_0093) begin failures++; $display("FAIL basic_e3 got=%b/%h/%h exp=1/4/00100093", dec_valid, dec_pc, dec_ins); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8 || dec_ins !== 32'h0020_0113) begin failures++; $display("FAIL basic_e4 got=%b/%h/%h exp=1/8/00200113", dec_valid, dec_pc, dec_ins); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [5] = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        do_reset(1'b0);
        repeat (10) tick();
        checks++; if (imem_pc !== 32'h10) begin failures++; $display("FAIL bp_hold_pc got=%h exp=10", imem_pc); end
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/0", dec_valid, dec_pc); end
        dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i] || dec_ins !== mem_word(exp_pc[i])) begin failures++; $display("FAIL bp_drain%0d got=%b/%h/%h exp=1/%h/%h", i, dec_valid, dec_pc, dec_ins, exp_pc[i], mem_word(exp_pc[i])); end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (4) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0022;
        tick();
        redirect = 1'b0;
        checks++; if (dec_valid !== 1'b0 || imem_pc !== 32'h20) begin failures++; $display("FAIL redir_k got=%b/%h exp=0/20", dec_valid, imem_pc); end
        tick();
        checks++; if (dec_valid !== 1'b0 || imem_pc !== 32'h24) begin failures++; $display("FAIL redir_k1 got=%b/%h exp=0/24", dec_valid, imem_pc); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h20 || dec_ins !== mem_word(32'h20)) begin failures++; $display("FAIL redir_k2 got=%b/%h/%h exp=1/20/%h", dec_valid, dec_pc, dec_ins, mem_word(32'h20)); end
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b1);
        repeat (2) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rpop_k got=%b exp=0", dec_valid); end
`ifdef IF_FETCH_PERF_EN
        checks++; if (perf_fetched !== 32'h0) begin failures++; $display("FAIL rpop_perf got=%0d exp=0", perf_fetched); end
`endif
        repeat (2) tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin failures++; $display("FAIL rpop_restart got=%b/%h exp=1/100", dec_valid, dec_pc); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (imem_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", imem_pc); end
        tick();
        checks++; if (imem_pc !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=0", imem_pc); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_head got=%b/%h exp=1/fffffffc", dec_valid, dec_pc); end
        tick();
        checks++; if (dec_pc !== 32'h0 || dec_ins !== 32'h0000_0013) begin failures++; $display("FAIL wrap_head2 got=%h/%h exp=0/00000013", dec_pc, dec_ins); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_pc !== 32'h0 || dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_ins !== 32'h0) begin failures++; $display("FAIL mid_rst got=%h/%b/%h/%h exp=0/0/0/0", imem_pc, dec_valid, dec_pc, dec_ins); end
        @(negedge clk);
        rst_n = 1'b1;
        dec_ready = 1'b1;
        tick();
        checks++; if (dec_valid !== 1'b0 || imem_pc !== 32'h4) begin failures++; $display("FAIL mid_e1 got=%b/%h exp=0/4", dec_valid, imem_pc); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin failures++; $display("FAIL mid_e2 got=%b/%h exp=1/0", dec_valid, dec_pc); end
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf();
        do_reset(1'b1);
        repeat (7) tick();
        dec_ready = 1'b0;
        tick();
        checks++; if (perf_fetched !== 32'd5) begin failures++; $display("FAIL perf_pops got=%0d exp=5", perf_fetched); end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        checks++; if (perf_fetched !== 32'd5 || perf_flushed !== 32'd3) begin failures++; $display("FAIL perf_flush got=%0d/%0d exp=5/3", perf_fetched, perf_flushed); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
`ifdef IF_FETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
